// File: rtl/fifo_uart_tx.sv
// Drains a fifo word by word and sends each one as an async UART frame:
// start bit, data bits LSB first, optional even-parity bit, then stop bits.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] fifo_dout_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DataLast = BW'(WIDTH - 1);
  localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StStart, StData, StParity, StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             parity_q, parity_d;
  logic             bit_end;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
    end
  end

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    fifo_rd_en_o = 1'b0;
    tx_o         = 1'b1;
    frame_done_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by reset so a held reset with a non-empty fifo never pops.
        fifo_rd_en_o = reset_i & enable_i & ~fifo_empty_i;
        cnt_d        = '0;
        bit_d        = '0;
        if (fifo_rd_en_o) state_d = StFetch;
      end
      StFetch: begin
        shreg_d  = fifo_dout_i;
        parity_d = ^fifo_dout_i;
        state_d  = StStart;
      end
      StStart: begin
        tx_o  = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx_o  = shreg_q[0];
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        tx_o  = parity_q;
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == StopLast) begin
            bit_d        = '0;
            frame_done_o = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle) | fifo_rd_en_o;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one DUT without parity, one with parity,
// each fed by a small behavioural fifo.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic enable_i = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // fifo models: index 0 feeds the plain DUT, index 1 the parity DUT
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [3:0] wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
  logic [7:0] dout0 = '0, dout1 = '0;
  logic       empty0, empty1;
  logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (rd0) begin
      dout0 <= mem0[rp0];
      rp0   <= rp0 + 4'd1;
    end
    if (rd1) begin
      dout1 <= mem1[rp1];
      rp1   <= rp1 + 4'd1;
    end
  end

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .fifo_dout_i(dout0),
    .fifo_empty_i(empty0), .fifo_rd_en_o(rd0), .tx_o(tx0), .busy_o(busy0),
    .frame_done_o(done0)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_p (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .fifo_dout_i(dout1),
    .fifo_empty_i(empty1), .fifo_rd_en_o(rd1), .tx_o(tx1), .busy_o(busy1),
    .frame_done_o(done1)
  );

  task automatic push(input bit p, input logic [7:0] d);
    if (p) begin
      mem1[wp1] = d;
      wp1 = wp1 + 4'd1;
    end else begin
      mem0[wp0] = d;
      wp0 = wp0 + 4'd1;
    end
  endtask

  // Expected line level k cycles after the pop cycle (k=0 is the IDLE pop cycle).
  function automatic logic exp_tx(input logic [7:0] w, input bit p, input int k);
    int slot;
    if (k < 2) return 1'b1;
    slot = (k - 2) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return w[slot-1];
    if (p && slot == 9) return ^w;
    return 1'b1;
  endfunction

  // Waits for a pop, then checks every cycle of the frame that follows it.
  task automatic check_frame(input bit p, input logic [7:0] w, input int drop_k,
                             input bit b2b, input string nm);
    int  waited = 0;
    bit  got = 0;
    int  len = 2 + CPB * (1 + 8 + int'(p) + 1);
    logic a_tx, a_busy, a_done, a_rd;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      waited++;
      if ((p ? rd1 : rd0) === 1'b1) begin
        got = 1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s pop: rd_en got 0 required 1 within 300 clks", nm);
      return;
    end
    if (b2b) begin
      total++;
      if (waited != 1) begin
        bad++;
        $display("FAIL %s gap: pop after %0d clks required 1", nm, waited);
      end
    end
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      a_tx   = p ? tx1 : tx0;
      a_busy = p ? busy1 : busy0;
      a_done = p ? done1 : done0;
      a_rd   = p ? rd1 : rd0;
      total += 4;
      if (a_tx !== exp_tx(w, p, k)) begin
        bad++;
        $display("FAIL %s tx k=%0d: got %b required %b", nm, k, a_tx, exp_tx(w, p, k));
      end
      if (a_busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy k=%0d: got %b required 1", nm, k, a_busy);
      end
      if (a_done !== (k == len - 1)) begin
        bad++;
        $display("FAIL %s done k=%0d: got %b required %b", nm, k, a_done, k == len - 1);
      end
      if (a_rd !== (k == 0)) begin
        bad++;
        $display("FAIL %s rd_en k=%0d: got %b required %b", nm, k, a_rd, k == 0);
      end
      if (k == drop_k) enable_i = 1'b0;
    end
  endtask

  task automatic check_quiet(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if (rd0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
        bad++;
        $display("FAIL %s cyc %0d: rd/tx/busy/done got %b%b%b%b required 0100",
                 nm, i, rd0, tx0, busy0, done0);
      end
    end
  endtask

  task automatic test_reset();
    push(0, 8'hF0);
    enable_i = 1'b1;
    check_quiet(5, "reset_hold");
    total++;
    if (rd1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_par: rd/tx/busy/done got %b%b%b%b required 0100",
               rd1, tx1, busy1, done1);
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
  endtask

  task automatic test_single();
    check_frame(0, 8'hF0, -1, 0, "single");
    check_quiet(3, "single_after");
  endtask

  task automatic test_empty();
    check_quiet(100, "empty");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push(0, 8'hF0);
    for (int i = 0; i < 8; i++) check_frame(0, 8'hF0, -1, i != 0, "burst");
    total++;
    if (empty0 !== 1'b1) begin
      bad++;
      $display("FAIL burst_empty: fifo empty got %b required 1", empty0);
    end
    check_quiet(20, "burst_no9th");
  endtask

  task automatic test_patterns();
    @(posedge clk); #1;
    push(0, 8'hA5);
    push(0, 8'h01);
    push(0, 8'h80);
    check_frame(0, 8'hA5, -1, 0, "pat_a5");
    check_frame(0, 8'h01, -1, 1, "pat_01");
    check_frame(0, 8'h80, -1, 1, "pat_80");
    check_quiet(5, "pat_after");
  endtask

  task automatic test_parity();
    @(posedge clk); #1;
    push(1, 8'h13);
    push(1, 8'h12);
    check_frame(1, 8'h13, -1, 0, "par_13");
    check_frame(1, 8'h12, -1, 1, "par_12");
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    @(posedge clk); #1;
    push(0, 8'hF0);
    push(0, 8'h3C);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd0 === 1'b1) begin
        got = 1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rmid pop: rd_en got 0 required 1");
    end
    // k=19 sits inside data bit 3, which is 0 for 0xF0
    repeat (19) @(negedge clk);
    total++;
    if (tx0 !== 1'b0) begin
      bad++;
      $display("FAIL rmid pre: tx got %b required 0", tx0);
    end
    reset_i = 1'b0;
    #1;
    total++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0) begin
      bad++;
      $display("FAIL rmid async: tx/busy/rd got %b%b%b required 100", tx0, busy0, rd0);
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
    check_frame(0, 8'h3C, -1, 0, "rmid_next");
    check_quiet(5, "rmid_after");
  endtask

  task automatic test_enable_drop();
    @(posedge clk); #1;
    enable_i = 1'b1;
    push(0, 8'h5A);
    push(0, 8'hC3);
    check_frame(0, 8'h5A, 3, 0, "edrop_w1");
    check_quiet(50, "edrop_hold");
    @(posedge clk); #1;
    enable_i = 1'b1;
    check_frame(0, 8'hC3, -1, 0, "edrop_w2");
    check_quiet(5, "edrop_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty();
    test_back_to_back();
    test_patterns();
    test_parity();
    test_reset_mid();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
